// File: rtl/bch_31_decoder.sv
// bch_31_decoder: iterative decoder for the binary BCH(31,21) code, t=2.
// Generator g(x)=x^10+x^9+x^8+x^6+x^5+x^3+1, GF(2^5) built on x^5+x^2+1.
// Codeword layout is {msg[20:0], parity[9:0]}; in_cw bit i is the x^i term.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   in_valid     in_cw holds a received word
//   in_ready     decoder is idle and will take in_cw
//   in_cw[30:0]  received word
//   out_valid    out_* hold a decode result
//   out_ready    consumer takes the result
//   out_msg      corrected message (bits 30:10 of the corrected word)
//   out_err_cnt  number of bits corrected (0..2)
//   out_fail     uncorrectable pattern; out_msg is then the raw in_cw[30:10]
//
// Fixed latency: out_valid rises 63 edges after the accepting edge
// (31 syndrome cycles, 1 solve cycle, 31 Chien cycles).
module bch_31_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [30:0] in_cw,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [20:0] out_msg,
  output logic [1:0]  out_err_cnt,
  output logic        out_fail
);

  typedef enum logic [2:0] {IDLE, SYND, SOLVE, CHIEN, DONE} state_t;

  localparam logic [4:0] ALPHA1     = 5'b00010;  // alpha
  localparam logic [4:0] ALPHA3     = 5'b01000;  // alpha^3
  localparam logic [4:0] ALPHA_INV1 = 5'b10010;  // alpha^30 = alpha^-1
  localparam logic [4:0] ALPHA_INV2 = 5'b01001;  // alpha^29 = alpha^-2
  localparam logic [4:0] LAST       = 5'd30;

  // GF(2^5) multiply, shift-and-add with reduction by x^5 = x^2 + 1.
  function automatic logic [4:0] gf_mul(input logic [4:0] a, input logic [4:0] b);
    logic [4:0] p;
    logic [4:0] aa;
    // NOTE: blocking assignments here are intended; each line reads the value just computed.
    p  = '0;
    aa = a;
    for (int k = 0; k < 5; k++) begin
      if (b[k]) p ^= aa;
      aa = {aa[3:0], 1'b0} ^ (aa[4] ? 5'b00101 : 5'b00000);
    end
    return p;
  endfunction

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [30:0] rx;        // received word, kept unmodified for the fail path
  logic [30:0] mask;      // accumulated error locations
  logic [4:0]  s1, s3;
  logic [4:0]  sig0, t1, t2;
  logic [1:0]  deg, roots;
  logic        fail_flag;

  // Solve-stage arithmetic.
  logic [4:0]  s1_sq, s1_cube, sig2_c;
  logic [1:0]  deg_c;
  // Chien-stage arithmetic.
  logic        rx_bit, hit, bad;
  logic [30:0] mask_nxt;
  logic [1:0]  roots_nxt;

  assign rx_bit    = rx[LAST - cnt];
  assign s1_sq     = gf_mul(s1, s1);
  assign s1_cube   = gf_mul(s1, s1_sq);
  assign sig2_c    = s3 ^ s1_cube;
  assign deg_c     = (sig2_c != 5'd0) ? 2'd2 : ((s1 != 5'd0) ? 2'd1 : 2'd0);

  // sigma(alpha^-i) = sig0 + t1 + t2; a zero marks bit i as in error.
  assign hit       = ((sig0 ^ t1 ^ t2) == 5'd0) && (deg != 2'd0);
  assign mask_nxt  = hit ? (mask | (31'(1) << cnt)) : mask;
  assign roots_nxt = roots + {1'b0, hit};
  assign bad       = fail_flag || (roots_nxt != deg);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first, so no path leaves state_nxt unassigned and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)       state_nxt = SYND;
      SYND:    if (cnt == LAST)    state_nxt = SOLVE;
      SOLVE:                       state_nxt = CHIEN;
      CHIEN:   if (cnt == LAST)    state_nxt = DONE;
      DONE:    if (out_ready)      state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; in_ready is held low for the whole time rst is high.
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
  end

  // Datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      rx          <= '0;
      mask        <= '0;
      s1          <= '0;
      s3          <= '0;
      sig0        <= '0;
      t1          <= '0;
      t2          <= '0;
      deg         <= '0;
      roots       <= '0;
      fail_flag   <= 1'b0;
      out_msg     <= '0;
      out_err_cnt <= '0;
      out_fail    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          rx    <= in_cw;
          s1    <= '0;
          s3    <= '0;
          cnt   <= '0;
          mask  <= '0;
          roots <= '0;
        end
        SYND: begin
          // Horner: bits enter high to low, so S1 = sum r_i alpha^i, S3 = sum r_i alpha^3i.
          s1  <= gf_mul(s1, ALPHA1) ^ {4'b0, rx_bit};
          s3  <= gf_mul(s3, ALPHA3) ^ {4'b0, rx_bit};
          cnt <= (cnt == LAST) ? 5'd0 : cnt + 5'd1;
        end
        SOLVE: begin
          // Scaled Peterson locator: sigma(x) = S1 * prod(1 + X_k x); no division needed.
          sig0      <= s1;
          t1        <= s1_sq;
          t2        <= sig2_c;
          deg       <= deg_c;
          fail_flag <= (s1 == 5'd0) && (s3 != 5'd0);
        end
        CHIEN: begin
          t1    <= gf_mul(t1, ALPHA_INV1);
          t2    <= gf_mul(t2, ALPHA_INV2);
          mask  <= mask_nxt;
          roots <= roots_nxt;
          cnt   <= (cnt == LAST) ? 5'd0 : cnt + 5'd1;
          if (cnt == LAST) begin
            out_msg     <= bad ? rx[30:10] : (rx[30:10] ^ mask_nxt[30:10]);
            out_err_cnt <= bad ? 2'd0 : deg;
            out_fail    <= bad;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
